// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_sequencer
// Description : Wishbone classic master that steps through a small table of
//               8-bit LED patterns. Each step issues one single-beat write,
//               then dwells a programmable number of cycles. Writes that are
//               never acknowledged are aborted after a bounded wait and
//               flagged on a sticky timeout output.
// Revision    : 1.0 - initial release
// ============================================================================
module led_sequencer #(
  parameter int NUM_PATTERNS   = 8,
  parameter int DWELL_WIDTH    = 24,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            enable_i,
  input  logic [DWELL_WIDTH-1:0]          dwell_i,
  input  logic [$clog2(NUM_PATTERNS)-1:0] last_index_i,
  input  logic                            load_i,
  input  logic [$clog2(NUM_PATTERNS)-1:0] load_index_i,
  input  logic [7:0]                      load_data_i,
  input  logic                            clear_timeout_i,
  output logic                            cyc_o,
  output logic                            stb_o,
  output logic                            we_o,
  output logic [7:0]                      dat_o,
  input  logic                            ack_i,
  output logic                            busy_o,
  output logic [$clog2(NUM_PATTERNS)-1:0] index_o,
  output logic                            timeout_o
);

  localparam int IW = $clog2(NUM_PATTERNS);
  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t                 state_q;
  logic [7:0]             table_q [NUM_PATTERNS];
  logic [IW-1:0]          index_q;
  logic [IW-1:0]          step_index_d;
  logic [7:0]             dat_q;
  logic                   cyc_q;
  logic                   busy_q;
  logic                   timeout_q;
  logic [TW-1:0]          to_cnt_q;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q;

  // Next table index on a step advance; >= compare clamps out-of-range limits.
  always_comb begin
    step_index_d = (index_q >= last_index_i) ? '0 : index_q + 1'b1;
  end

  // Pattern table: written at any time, read only when a write is launched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PATTERNS; i++) begin
        table_q[i] <= 8'h00;
      end
    end else if (load_i) begin
      table_q[load_index_i] <= load_data_i;
    end
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      index_q     <= '0;
      dat_q       <= 8'h00;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      to_cnt_q    <= '0;
      dwell_cnt_q <= '0;
    end else begin
      // Clear first so an abort in the same cycle overrides it.
      if (clear_timeout_i) begin
        timeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q  <= WRITE;
            index_q  <= '0;
            dat_q    <= table_q[0];
            cyc_q    <= 1'b1;
            busy_q   <= 1'b1;
            to_cnt_q <= '0;
          end
        end
        WRITE: begin
          // Ack on the expiry cycle still counts as a successful write.
          if (ack_i || (to_cnt_q == TO_LAST)) begin
            cyc_q       <= 1'b0;
            dwell_cnt_q <= dwell_i;
            if (!ack_i) begin
              timeout_q <= 1'b1;
            end
            if (enable_i) begin
              state_q <= DWELL;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DWELL: begin
          if (!enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (dwell_cnt_q == '0) begin
            state_q  <= WRITE;
            index_q  <= step_index_d;
            dat_q    <= table_q[step_index_d];
            cyc_q    <= 1'b1;
            to_cnt_q <= '0;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cyc_o     = cyc_q;
  assign stb_o     = cyc_q;
  assign we_o      = cyc_q;
  assign dat_o     = dat_q;
  assign busy_o    = busy_q;
  assign index_o   = index_q;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_led_sequencer
// Description : Self-checking bench for led_sequencer: a cycle-by-cycle
//               vector table followed by hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_sequencer;

  localparam int NP = 8;
  localparam int DW = 24;
  localparam int TO = 16;
  localparam int IW = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic [DW-1:0] dwell_i = '0;
  logic [IW-1:0] last_index_i = '0;
  logic          load_i = 1'b0;
  logic [IW-1:0] load_index_i = '0;
  logic [7:0]    load_data_i = 8'h00;
  logic          clear_timeout_i = 1'b0;
  logic          cyc_o, stb_o, we_o;
  logic [7:0]    dat_o;
  logic          ack_i = 1'b0;
  logic          busy_o;
  logic [IW-1:0] index_o;
  logic          timeout_o;

  led_sequencer #(
    .NUM_PATTERNS  (NP),
    .DWELL_WIDTH   (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .dwell_i        (dwell_i),
    .last_index_i   (last_index_i),
    .load_i         (load_i),
    .load_index_i   (load_index_i),
    .load_data_i    (load_data_i),
    .clear_timeout_i(clear_timeout_i),
    .cyc_o          (cyc_o),
    .stb_o          (stb_o),
    .we_o           (we_o),
    .dat_o          (dat_o),
    .ack_i          (ack_i),
    .busy_o         (busy_o),
    .index_o        (index_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          en;
    logic          ack;
    logic          ld;
    logic [IW-1:0] lidx;
    logic [7:0]    ldat;
    logic          e_cyc;
    logic [7:0]    e_dat;
    logic [IW-1:0] e_idx;
    logic          e_busy;
  } vec_t;

  vec_t vecs [17];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] idx, input logic [7:0] data);
    load_i = 1'b1; load_index_i = idx; load_data_i = data;
    step();
    load_i = 1'b0;
  endtask

  // Steps until cyc_o rises or the budget runs out; n = steps taken.
  task automatic wait_cyc(input int maxc, output int n);
    n = 0;
    while (cyc_o !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk("wait_cyc_budget", cyc_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    int rises;
    logic prev;
    logic [7:0] exp_seq [5];

    //           en   ack  ld   lidx ldat    cyc  dat    idx  busy
    vecs[0]  = '{1'b0,1'b0,1'b1,3'd0,8'hA1, 1'b0,8'h00, 3'd0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b1,3'd1,8'hB2, 1'b0,8'h00, 3'd0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,3'd2,8'hC3, 1'b0,8'h00, 3'd0,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hA1, 3'd0,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hA1, 3'd0,1'b1};
    vecs[5]  = '{1'b1,1'b1,1'b0,3'd0,8'h00, 1'b0,8'hA1, 3'd0,1'b1};
    vecs[6]  = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b0,8'hA1, 3'd0,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hB2, 3'd1,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b0,3'd0,8'h00, 1'b0,8'hB2, 3'd1,1'b1};
    vecs[9]  = '{1'b1,1'b1,1'b0,3'd0,8'h00, 1'b0,8'hB2, 3'd1,1'b1};
    vecs[10] = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hC3, 3'd2,1'b1};
    vecs[11] = '{1'b1,1'b1,1'b0,3'd0,8'h00, 1'b0,8'hC3, 3'd2,1'b1};
    vecs[12] = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b0,8'hC3, 3'd2,1'b1};
    vecs[13] = '{1'b1,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hA1, 3'd0,1'b1};
    vecs[14] = '{1'b0,1'b0,1'b0,3'd0,8'h00, 1'b1,8'hA1, 3'd0,1'b1};
    vecs[15] = '{1'b0,1'b1,1'b0,3'd0,8'h00, 1'b0,8'hA1, 3'd0,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,3'd0,8'h00, 1'b0,8'hA1, 3'd0,1'b0};

    // Reset state
    step(); step();
    rst_i = 1'b0;
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_idx", index_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);

    // Table-driven run: dwell 1, wrap after index 2
    dwell_i = 24'd1;
    last_index_i = 3'd2;
    for (int i = 0; i < 17; i++) begin
      enable_i = vecs[i].en; ack_i = vecs[i].ack;
      load_i = vecs[i].ld; load_index_i = vecs[i].lidx; load_data_i = vecs[i].ldat;
      step();
      chk($sformatf("vec%0d_cyc", i), cyc_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_stb", i), stb_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_we", i), we_o, vecs[i].e_cyc);
      chk($sformatf("vec%0d_dat", i), dat_o, vecs[i].e_dat);
      chk($sformatf("vec%0d_idx", i), index_o, vecs[i].e_idx);
      chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].e_busy);
      chk($sformatf("vec%0d_to", i), timeout_o, 0);
    end
    load_i = 1'b0; ack_i = 1'b0;

    // Four-pattern walk with ack tied high: entries 6 cycles apart
    load(3'd0, 8'h01); load(3'd1, 8'h02); load(3'd2, 8'h04); load(3'd3, 8'h08);
    dwell_i = 24'd4; last_index_i = 3'd3;
    exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h04;
    exp_seq[3] = 8'h08; exp_seq[4] = 8'h01;
    ack_i = 1'b1; enable_i = 1'b1;
    step();
    chk("walk_first_cyc", cyc_o, 1);
    chk("walk_first_dat", dat_o, exp_seq[0]);
    prev = cyc_o; t = 0; rises = 1;
    for (int c = 0; c < 40 && rises < 5; c++) begin
      step();
      t++;
      if (cyc_o && !prev) begin
        chk($sformatf("walk%0d_spacing", rises), t, 6);
        chk($sformatf("walk%0d_dat", rises), dat_o, exp_seq[rises]);
        t = 0;
        rises++;
      end
      prev = cyc_o;
    end
    chk("walk_count", rises, 5);
    enable_i = 1'b0;
    step();
    chk("walk_stop_busy", busy_o, 0);

    // Drop enable in DWELL at index 2, then restart from index 0
    enable_i = 1'b1;
    step();
    n = 0;
    while (!(index_o == 3'd2 && cyc_o == 1'b0) && n < 30) begin
      step();
      n++;
    end
    chk("drop_reach_idx2", index_o, 2);
    enable_i = 1'b0;
    step();
    chk("drop_busy", busy_o, 0);
    chk("drop_idx_hold", index_o, 2);
    step(); step(); step();
    chk("drop_no_cyc", cyc_o, 0);
    enable_i = 1'b1;
    step();
    chk("reenter_cyc", cyc_o, 1);
    chk("reenter_idx", index_o, 0);
    chk("reenter_dat", dat_o, 8'h01);
    enable_i = 1'b0;
    step();
    step();

    // Ack delayed 3 cycles: bus held 4 cycles, dwell counted after ack
    ack_i = 1'b0; enable_i = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("delay%0d_cyc", k), cyc_o, 1);
      chk($sformatf("delay%0d_dat", k), dat_o, 8'h01);
    end
    ack_i = 1'b1;
    step();
    chk("delay_ack_drop", cyc_o, 0);
    ack_i = 1'b0;
    wait_cyc(10, n);
    chk("delay_dwell_len", n, 5);
    chk("delay_next_idx", index_o, 1);
    chk("delay_next_dat", dat_o, 8'h02);

    // No ack: cyc_o held exactly 16 cycles, then abort and advance
    dwell_i = 24'd0;
    for (int k = 0; k < 15; k++) step();
    chk("to_cyc_still_high", cyc_o, 1);
    chk("to_not_yet", timeout_o, 0);
    step();
    chk("to_cyc_dropped", cyc_o, 0);
    chk("to_set", timeout_o, 1);
    step();
    chk("to_advance_cyc", cyc_o, 1);
    chk("to_advance_idx", index_o, 2);
    clear_timeout_i = 1'b1;
    step();
    clear_timeout_i = 1'b0;
    chk("to_cleared", timeout_o, 0);

    // Ack on the expiry cycle counts as ack
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    step();
    chk("exp_entry_idx", index_o, 3);
    chk("exp_entry_dat", dat_o, 8'h08);
    for (int k = 0; k < 15; k++) step();
    chk("exp_cyc_high", cyc_o, 1);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("exp_cyc_drop", cyc_o, 0);
    chk("exp_no_timeout", timeout_o, 0);

    // Abort and clear in the same cycle: set wins
    step();
    chk("sc_wrap_idx", index_o, 0);
    for (int k = 0; k < 15; k++) step();
    clear_timeout_i = 1'b1;
    step();
    clear_timeout_i = 1'b0;
    chk("sc_set_wins", timeout_o, 1);
    step();
    enable_i = 1'b0; ack_i = 1'b1;
    step();
    chk("sc_idle_busy", busy_o, 0);
    ack_i = 1'b0;

    // Load into the current index mid-WRITE: old data kept, new data next visit
    clear_timeout_i = 1'b1;
    step();
    clear_timeout_i = 1'b0;
    last_index_i = 3'd0; dwell_i = 24'd0; enable_i = 1'b1;
    step();
    chk("ld_entry_dat", dat_o, 8'h01);
    load(3'd0, 8'hFF);
    chk("ld_keep_cyc", cyc_o, 1);
    chk("ld_keep_dat", dat_o, 8'h01);
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("ld_dwell_cyc", cyc_o, 0);
    step();
    chk("ld_next_cyc", cyc_o, 1);
    chk("ld_next_idx", index_o, 0);
    chk("ld_next_dat", dat_o, 8'hFF);

    // Asynchronous reset in the middle of a WRITE
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_cyc", cyc_o, 0);
    chk("arst_stb", stb_o, 0);
    chk("arst_idx", index_o, 0);
    chk("arst_busy", busy_o, 0);
    enable_i = 1'b0;
    step();
    rst_i = 1'b0;
    step(); step(); step();
    chk("arst_no_writes", cyc_o, 0);
    enable_i = 1'b1; ack_i = 1'b1;
    step();
    chk("arst_restart_cyc", cyc_o, 1);
    chk("arst_restart_idx", index_o, 0);
    chk("arst_table_cleared", dat_o, 8'h00);
    enable_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Wishbone classic controller that drives the LED register block: holds a small table of 8-bit LED patterns and steps through it, issuing one single-beat write per step, then dwelling a programmable number of cycles. Sits between software/config logic and the LED device's wishbone port; pattern byte layout matches the LED state register (bits 3:0 green, bits 7:4 RGB). Detects unacknowledged writes with a bounded timeout.

Parameters:
NUM_PATTERNS, 8, pattern table depth (power of two, >=2)
DWELL_WIDTH, 24, width of the dwell counter
TIMEOUT_CYCLES, 16, max cycles a write waits for ack before abort (>=1)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
enable_i  input  1  run sequencer
dwell_i  input  DWELL_WIDTH  dwell length; step holds dwell_i+1 cycles after ack
last_index_i  input  $clog2(NUM_PATTERNS)  final table index before wrap
load_i  input  1  table write strobe
load_index_i  input  $clog2(NUM_PATTERNS)  table write address
load_data_i  input  8  table write data
clear_timeout_i  input  1  clears timeout_o
cyc_o  output  1  wishbone cycle
stb_o  output  1  wishbone strobe
we_o  output  1  wishbone write enable
dat_o  output  8  wishbone write data (pattern)
ack_i  input  1  wishbone acknowledge
busy_o  output  1  state != IDLE
index_o  output  $clog2(NUM_PATTERNS)  current step index
timeout_o  output  1  sticky: a write was aborted

Behaviour:
- Reset (async assert, sync deassert to clk_i): state IDLE, cyc_o=stb_o=we_o=0, dat_o=0, index_o=0, timeout_o=0, busy_o=0, table all zero, counters 0.
- States IDLE, WRITE, DWELL; all outputs registered.
- IDLE: enable_i=1 -> WRITE next cycle with index_o=0, dat_o=table[0]; cyc/stb/we=1 that same cycle.
- WRITE: cyc_o=stb_o=we_o=1, dat_o stable for whole transaction (captured at WRITE entry). Single beat.
  - ack_i=1 -> cyc/stb/we=0 next cycle, load dwell counter with dwell_i, go DWELL.
  - no ack for TIMEOUT_CYCLES consecutive WRITE cycles -> drop cyc/stb/we, set timeout_o, go DWELL (step skipped, sequence continues).
  - ack on the same cycle as timeout expiry counts as ack; timeout_o not set.
  - enable_i deassert in WRITE: transaction still completes (ack or timeout), then IDLE instead of DWELL.
- DWELL: counter decrements each cycle; lasts dwell_i+1 cycles (dwell_i=0 -> 1 cycle).
  - enable_i=0 any DWELL cycle -> IDLE next cycle, index_o holds.
  - counter==0 and enable_i=1 -> index_o = (index_o>=last_index_i) ? 0 : index_o+1; go WRITE.
- last_index_i sampled at each step advance; value beyond table clamps via >= compare (wraps to 0).
- Re-entry from IDLE always restarts at index 0.
- Table: load_i writes load_data_i to table[load_index_i] in any state; visible at next WRITE entry. Load to index currently on dat_o does not alter dat_o mid-transaction.
- timeout_o: set on abort, cleared by clear_timeout_i; simultaneous set and clear -> set wins.
- ack_i outside WRITE ignored.

Test Plan:
- Reset mid-WRITE (cyc_o=1) -> cyc_o/stb_o=0, index_o=0, busy_o=0 immediately, no further writes until enable_i.
- Load table[0..3]=8'h01,8'h02,8'h04,8'h08, last_index_i=3, dwell_i=4, ack_i tied 1 -> writes 01,02,04,08,01 in order, WRITE entries 6 cycles apart (1 WRITE + 5 DWELL).
- ack_i held 0, TIMEOUT_CYCLES=16 -> cyc_o high exactly 16 cycles, timeout_o=1, index advances; clear_timeout_i -> timeout_o=0.
- Ack delayed 3 cycles -> dat_o/cyc_o stable for 4 cycles, dwell starts after ack.
- enable_i dropped during DWELL at index 2 -> IDLE next cycle, no further cyc_o; re-enable -> first write uses table[0].
- load_i to current index during WRITE with 8'hFF -> current transaction keeps old data; next visit writes 8'hFF.
